// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the word-organised
// data memory. It checks alignment and range, inserts WAIT_CYCLES wait states,
// drives one ACCESS cycle and returns extended load data or an exception.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MEM_BYTES   = 12288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [13:0] mem_A,
  output logic [31:0] mem_WD,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_PC,
  input  logic [31:0] mem_RD
);

  localparam int unsigned CNT_W = 4;
  localparam logic        NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  localparam logic [2:0] T_LW  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LHU = 3'b010;
  localparam logic [2:0] T_LB  = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_SW  = 3'b101;
  localparam logic [2:0] T_SH  = 3'b110;
  localparam logic [2:0] T_SB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [2:0]        r_type;
  logic [13:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_pc;

  logic              w_misalign;
  logic              w_out_of_range;
  logic              w_exc;
  logic              w_is_load;
  logic [31:0]       w_load_data;

  // Alignment and range check on the incoming request.
  always_comb begin
    w_misalign = 1'b0;
    case (req_type)
      T_LW, T_SW:        w_misalign = (req_addr[1:0] != 2'b00);
      T_LH, T_LHU, T_SH: w_misalign = req_addr[0];
      default:           w_misalign = 1'b0;
    endcase
    w_out_of_range = (req_addr >= 32'(MEM_BYTES));
    w_exc          = w_misalign | w_out_of_range;
  end

  // Select and extend the addressed word/half/byte of the memory read word.
  always_comb begin
    logic [15:0] v_half;
    logic [7:0]  v_byte;
    v_half      = r_addr[1] ? mem_RD[31:16] : mem_RD[15:0];
    v_byte      = mem_RD[8*r_addr[1:0] +: 8];
    w_is_load   = 1'b1;
    w_load_data = '0;
    case (r_type)
      T_LW:    w_load_data = mem_RD;
      T_LH:    w_load_data = {{16{v_half[15]}}, v_half};
      T_LHU:   w_load_data = {16'h0000, v_half};
      T_LB:    w_load_data = {{24{v_byte[7]}}, v_byte};
      T_LBU:   w_load_data = {24'h000000, v_byte};
      default: begin
        w_is_load   = 1'b0;
        w_load_data = '0;
      end
    endcase
  end

  // Control FSM with request latches and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_type     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pc       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_type  <= req_type;
            r_addr  <= req_addr[13:0];
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
            if (w_exc) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_exc   <= 1'b1;
              rsp_rdata <= '0;
            end else if (NO_WAIT) begin
              r_state <= S_ACCESS;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= S_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        S_ACCESS: begin
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_exc   <= 1'b0;
          rsp_rdata <= w_is_load ? w_load_data : 32'h0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte enables exist only in ACCESS; async reset clears the state and hence these.
  always_comb begin
    mem_byteen = 4'b0000;
    if (r_state == S_ACCESS) begin
      case (r_type)
        T_SW:    mem_byteen = 4'b1111;
        T_SH:    mem_byteen = r_addr[1] ? 4'b1100 : 4'b0011;
        T_SB:    mem_byteen = 4'b0001 << r_addr[1:0];
        default: mem_byteen = 4'b0000;
      endcase
    end
  end

  // Lane-replicated write data, driven from the latches in every state.
  always_comb begin
    mem_WD = r_wdata;
    case (r_type)
      T_SH:    mem_WD = {2{r_wdata[15:0]}};
      T_SB:    mem_WD = {4{r_wdata[7:0]}};
      default: mem_WD = r_wdata;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_A     = r_addr;
  assign mem_PC    = r_pc;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte-enabled memory.
module tb_mem_access_ctrl;

  localparam int unsigned W = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic [13:0] mem_A;
  logic [31:0] mem_WD;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_PC;
  logic [31:0] mem_RD;

  logic [31:0] mem [4096];

  int checks;
  int errors;
  logic [31:0] held_rdata;

  mem_access_ctrl #(.WAIT_CYCLES(W), .MEM_BYTES(12288)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_exc(rsp_exc), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_byteen(mem_byteen), .mem_PC(mem_PC), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[13:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_byteen[b]) mem[mem_A[13:2]][8*b +: 8] <= mem_WD[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    req_pc    = pc;
    check("idle_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rsp_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_acc(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_exc, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    accept(t, a, wd, 32'h0000_0400 + a);
    if (exp_exc) begin
      check({tag, "_exc_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_exc_flag"}, 32'(rsp_exc), 32'd1);
      check({tag, "_exc_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_exc_be"}, 32'(mem_byteen), 32'h0);
    end else begin
      for (int i = 0; i < int'(W); i++) begin
        check({tag, "_wait_be"}, 32'(mem_byteen), 32'h0);
        check({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
        step();
      end
      check({tag, "_be"}, 32'(mem_byteen), 32'(exp_be));
      check({tag, "_A"}, 32'(mem_A), 32'(a[13:0]));
      check({tag, "_PC"}, mem_PC, 32'h0000_0400 + a);
      if (exp_be != 4'b0000) check({tag, "_WD"}, mem_WD, exp_wd);
      step();
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_exc"}, 32'(rsp_exc), 32'd0);
      check({tag, "_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_resp_be"}, 32'(mem_byteen), 32'h0);
    end
    finish_rsp();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_type  = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_pc    = 32'h0;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_exc", 32'(rsp_exc), 32'd0);
    check("rst_byteen", 32'(mem_byteen), 32'h0);
    check("rst_mem_A", 32'(mem_A), 32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // Word store then byte/half stores and extended loads
    run_acc("sw10", 3'b101, 32'h0010, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    check("mem4_sw", mem[4], 32'hDEADBEEF);
    run_acc("sb13", 3'b111, 32'h0013, 32'h000000AA, 1'b0, 4'b1000, 32'hAAAAAAAA, 32'h0);
    check("mem4_sb", mem[4], 32'hAAADBEEF);
    run_acc("lb13", 3'b011, 32'h0013, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFAA);
    run_acc("lbu13", 3'b100, 32'h0013, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000AA);
    run_acc("sh22", 3'b110, 32'h0022, 32'h00008001, 1'b0, 4'b1100, 32'h80018001, 32'h0);
    check("mem8_sh", mem[8], 32'h80010000);
    run_acc("lh22", 3'b001, 32'h0022, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF8001);
    run_acc("lhu22", 3'b010, 32'h0022, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00008001);
    run_acc("lw10", 3'b000, 32'h0010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hAAADBEEF);
    run_acc("lb11", 3'b011, 32'h0011, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFBE);
    run_acc("sh_lo", 3'b110, 32'h0020, 32'h0000_7F02, 1'b0, 4'b0011, 32'h7F027F02, 32'h0);
    check("mem8_shlo", mem[8], 32'h80017F02);
    run_acc("lb2fff", 3'b011, 32'h2FFF, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);

    // Exceptions: no write, response one cycle after accept
    run_acc("lw02", 3'b000, 32'h0002, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    run_acc("sh01", 3'b110, 32'h0001, 32'h0000FFFF, 1'b1, 4'b0000, 32'h0, 32'h0);
    run_acc("sw3000", 3'b101, 32'h3000, 32'h12345678, 1'b1, 4'b0000, 32'h0, 32'h0);
    check("mem0_unch", mem[0], 32'h0);
    check("memC00_unch", mem[12'hC00], 32'h0);

    // Response held under backpressure; requests ignored outside IDLE
    accept(3'b000, 32'h0010, 32'h0, 32'h0000_0500);
    step();
    step();
    held_rdata = rsp_rdata;
    check("hold_first_rdata", held_rdata, 32'hAAADBEEF);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2) == 0;
      req_type  = 3'b101;
      req_addr  = 32'h0040;
      req_wdata = 32'h12345678;
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, held_rdata);
      check("hold_exc", 32'(rsp_exc), 32'd0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_be", 32'(mem_byteen), 32'h0);
    end
    req_valid = 1'b0;
    finish_rsp();
    step();
    check("hold_idle_be", 32'(mem_byteen), 32'h0);
    check("mem16_unwritten", mem[16], 32'h0);

    // Async reset during the ACCESS cycle of a store
    accept(3'b101, 32'h0050, 32'hCAFEF00D, 32'h0000_0600);
    step();
    check("rstacc_be_before", 32'(mem_byteen), 32'hF);
    #1 reset = 1'b1;
    #1;
    check("rstacc_be", 32'(mem_byteen), 32'h0);
    check("rstacc_ready", 32'(req_ready), 32'd1);
    check("rstacc_valid", 32'(rsp_valid), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("rstacc_ready_rel", 32'(req_ready), 32'd1);
    check("rstacc_valid_rel", 32'(rsp_valid), 32'd0);
    check("rstacc_mem", mem[20], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
